// File: rtl/stream_splitter_if.sv
// Valid/ready stream bundle used for the splitter input and both branch outputs.
// The master drives valid/data, the slave drives ready.
interface stream_splitter_if #(
  parameter int unsigned W = 32
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/stream_splitter.sv
// One-into-two stream fork: each accepted input beat is split into a low field
// for branch 0 and a high field for branch 1, each behind a main+skid buffer.

module stream_splitter_branch #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         accept,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         skid_full
);
  logic         mvld_q, mvld_d;
  logic [W-1:0] mdat_q, mdat_d;
  logic         svld_q, svld_d;
  logic [W-1:0] sdat_q, sdat_d;
  logic         pop;

  assign pop = mvld_q && out_ready;

  always_comb begin
    mvld_d = mvld_q;
    mdat_d = mdat_q;
    svld_d = svld_q;
    sdat_d = sdat_q;
    if (svld_q) begin
      // Input is blocked while the skid is occupied, so only a drain can happen.
      if (pop) begin
        mdat_d = sdat_q;
        svld_d = 1'b0;
      end
    end else if (accept && (!mvld_q || pop)) begin
      mdat_d = in_data;
      mvld_d = 1'b1;
    end else if (accept) begin
      sdat_d = in_data;
      svld_d = 1'b1;
    end else if (pop) begin
      mvld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mvld_q <= 1'b0;
      mdat_q <= '0;
      svld_q <= 1'b0;
      sdat_q <= '0;
    end else begin
      mvld_q <= mvld_d;
      mdat_q <= mdat_d;
      svld_q <= svld_d;
      sdat_q <= sdat_d;
    end
  end

  assign out_valid = mvld_q;
  assign out_data  = mdat_q;
  assign skid_full = svld_q;
endmodule

module stream_splitter #(
  parameter int unsigned WIDTH0 = 32,
  parameter int unsigned WIDTH1 = 32
) (
  input  logic               iCLK,
  input  logic               iRST,
  stream_splitter_if.slave   s_as,
  stream_splitter_if.master  m_bm0,
  stream_splitter_if.master  m_bm1
);
  logic accept;
  logic skid0_full, skid1_full;

  // Ready depends only on the skid flags and reset, never on downstream ready.
  assign s_as.ready = !iRST && !skid0_full && !skid1_full;
  assign accept     = s_as.valid && s_as.ready;

  stream_splitter_branch #(.W(WIDTH0)) u_branch0 (
    .clk       (iCLK),
    .rst       (iRST),
    .accept    (accept),
    .in_data   (s_as.data[WIDTH0-1:0]),
    .out_ready (m_bm0.ready),
    .out_valid (m_bm0.valid),
    .out_data  (m_bm0.data),
    .skid_full (skid0_full)
  );

  stream_splitter_branch #(.W(WIDTH1)) u_branch1 (
    .clk       (iCLK),
    .rst       (iRST),
    .accept    (accept),
    .in_data   (s_as.data[WIDTH1+WIDTH0-1:WIDTH0]),
    .out_ready (m_bm1.ready),
    .out_valid (m_bm1.valid),
    .out_data  (m_bm1.data),
    .skid_full (skid1_full)
  );
endmodule
